// File: rtl/shared_event_fifo.sv
// Shared event FIFO: accepts parity-protected events over the load_event/fifo_ack handshake
// and presents them first-word-fall-through to the comms controller, with occupancy and tally.
module shared_event_fifo #(
   parameter int WIDTH      = 64,
   parameter int FIFO_DEPTH = 2048,
   parameter int FIFO_BITS  = 11
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] channel_event_in,
   input  logic             load_event,
   output logic             fifo_ack,
   input  logic             read_fifo,
   output logic [WIDTH-1:0] fifo_data_out,
   output logic             fifo_empty,
   output logic             fifo_full,
   output logic             fifo_half,
   output logic [11:0]      fifo_counter,
   output logic [3:0]       total_packets_lsbs,
   output logic             fifo_overflow,
   output logic             parity_error,
   input  logic             clear_flags
);

   localparam logic [FIFO_BITS-1:0] PTR_ONE    = FIFO_BITS'(1);
   localparam logic [11:0]          COUNT_FULL = 12'(FIFO_DEPTH);
   localparam logic [11:0]          COUNT_HALF = 12'(FIFO_DEPTH / 2);

   function automatic logic parity_ok(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction

   logic [WIDTH-1:0]     mem_r [FIFO_DEPTH];
   logic [FIFO_BITS-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
   logic [11:0]          count_r, count_nxt_s;
   logic [WIDTH-1:0]     head_r, head_nxt_s;
   logic [3:0]           lsbs_r;
   logic                 ack_r, empty_r, full_r, half_r, overflow_r, perr_r;
   logic                 take_s, pop_s, wr_en_s, drop_s;

   // Handshake decode, next occupancy and next head-of-FIFO word
   always_comb begin
      take_s      = load_event & ~ack_r;
      pop_s       = read_fifo & ~empty_r;
      wr_en_s     = take_s & (~full_r | pop_s);
      drop_s      = take_s & full_r & ~pop_s;
      rd_next_s   = rd_ptr_r + PTR_ONE;
      count_nxt_s = count_r;
      head_nxt_s  = head_r;
      if (wr_en_s && !pop_s) begin
         count_nxt_s = count_r + 12'd1;
      end else if (pop_s && !wr_en_s) begin
         count_nxt_s = count_r - 12'd1;
      end else begin
         count_nxt_s = count_r;
      end
      // A pop of the last word while a write lands must forward the incoming word
      if (pop_s) begin
         if (wr_en_s && (count_r == 12'd1)) begin
            head_nxt_s = channel_event_in;
         end else begin
            head_nxt_s = mem_r[rd_next_s];
         end
      end else if (wr_en_s && empty_r) begin
         head_nxt_s = channel_event_in;
      end else begin
         head_nxt_s = head_r;
      end
   end

   // Event storage; contents are not reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= channel_event_in;
      end
   end

   // Pointers, occupancy, flags, sticky errors and handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= 12'd0;
         head_r     <= '0;
         lsbs_r     <= 4'd0;
         ack_r      <= 1'b0;
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
         half_r     <= 1'b0;
         overflow_r <= 1'b0;
         perr_r     <= 1'b0;
      end else begin
         ack_r   <= take_s;
         count_r <= count_nxt_s;
         head_r  <= head_nxt_s;
         empty_r <= (count_nxt_s == 12'd0);
         full_r  <= (count_nxt_s == COUNT_FULL);
         half_r  <= (count_nxt_s >= COUNT_HALF);
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            lsbs_r   <= lsbs_r + 4'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_next_s;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clear_flags) begin
            overflow_r <= 1'b0;
         end
         if (take_s && !parity_ok(channel_event_in)) begin
            perr_r <= 1'b1;
         end else if (clear_flags) begin
            perr_r <= 1'b0;
         end
      end
   end

   assign fifo_ack           = ack_r;
   assign fifo_data_out      = head_r;
   assign fifo_empty         = empty_r;
   assign fifo_full          = full_r;
   assign fifo_half          = half_r;
   assign fifo_counter       = count_r;
   assign total_packets_lsbs = lsbs_r;
   assign fifo_overflow      = overflow_r;
   assign parity_error       = perr_r;

endmodule

// File: tb/tb_shared_event_fifo.sv
// Directed bench for shared_event_fifo at FIFO_DEPTH=16: vector table plus fill, wrap and reset sequences.
module tb_shared_event_fifo;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] channel_event_in;
   logic        load_event, read_fifo, clear_flags;
   logic        fifo_ack, fifo_empty, fifo_full, fifo_half, fifo_overflow, parity_error;
   logic [63:0] fifo_data_out;
   logic [11:0] fifo_counter;
   logic [3:0]  total_packets_lsbs;

   int n_vec = 0;
   int n_err = 0;

   shared_event_fifo #(.WIDTH(64), .FIFO_DEPTH(16), .FIFO_BITS(4)) dut (
      .clk(clk), .reset_n(reset_n), .channel_event_in(channel_event_in),
      .load_event(load_event), .fifo_ack(fifo_ack), .read_fifo(read_fifo),
      .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .fifo_half(fifo_half), .fifo_counter(fifo_counter),
      .total_packets_lsbs(total_packets_lsbs), .fifo_overflow(fifo_overflow),
      .parity_error(parity_error), .clear_flags(clear_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld, rd, clr;
      logic [63:0] din;
      logic        ack, emp, full, half;
      logic [11:0] cnt;
      logic [3:0]  lsb;
      logic        ovf, perr, cd;
      logic [63:0] dout;
   } vec_t;

   function automatic logic [63:0] mkw(input logic [62:0] p);
      return {~^p, p};
   endfunction

   function automatic vec_t v(input logic ld, rd, clr, input logic [63:0] din,
                              input logic ack, emp, input logic [11:0] cnt,
                              input logic [3:0] lsb, input logic perr, cd,
                              input logic [63:0] dout);
      vec_t r;
      r.ld = ld; r.rd = rd; r.clr = clr; r.din = din;
      r.ack = ack; r.emp = emp; r.full = 1'b0; r.half = 1'b0;
      r.cnt = cnt; r.lsb = lsb; r.ovf = 1'b0; r.perr = perr; r.cd = cd; r.dout = dout;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic ld, rd, clr, input logic [63:0] din);
      load_event = ld; read_fifo = rd; clear_flags = clr; channel_event_in = din;
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [63:0] w, input string nm);
      drive(1'b1, 1'b0, 1'b0, w);
      chk({nm, " ack"}, 64'(fifo_ack), 64'd1);
      drive(1'b0, 1'b0, 1'b0, 64'd0);
      chk({nm, " ack low"}, 64'(fifo_ack), 64'd0);
   endtask

   task automatic check_reset_state(input string nm);
      chk({nm, " ack"},   64'(fifo_ack), 64'd0);
      chk({nm, " empty"}, 64'(fifo_empty), 64'd1);
      chk({nm, " full"},  64'(fifo_full), 64'd0);
      chk({nm, " half"},  64'(fifo_half), 64'd0);
      chk({nm, " cnt"},   64'(fifo_counter), 64'd0);
      chk({nm, " lsbs"},  64'(total_packets_lsbs), 64'd0);
      chk({nm, " ovf"},   64'(fifo_overflow), 64'd0);
      chk({nm, " perr"},  64'(parity_error), 64'd0);
   endtask

   initial begin
      vec_t        tbl[27];
      logic [63:0] q[$];
      logic [63:0] w1, bad, w;
      w1  = 64'hC000_0000_0000_0001;
      bad = 64'h4000_0000_0000_0001;

      //      ld    rd    clr   din                    ack   emp   cnt    lsb   perr  cd    dout
      tbl[0]  = v(1'b1, 1'b0, 1'b0, w1,                1'b1, 1'b0, 12'd1, 4'd1, 1'b0, 1'b1, w1);
      tbl[1]  = v(1'b1, 1'b0, 1'b0, w1,                1'b0, 1'b0, 12'd1, 4'd1, 1'b0, 1'b1, w1);
      tbl[2]  = v(1'b0, 1'b0, 1'b0, 64'd0,             1'b0, 1'b0, 12'd1, 4'd1, 1'b0, 1'b1, w1);
      tbl[3]  = v(1'b1, 1'b0, 1'b0, bad,               1'b1, 1'b0, 12'd2, 4'd2, 1'b1, 1'b1, w1);
      tbl[4]  = v(1'b0, 1'b0, 1'b0, 64'd0,             1'b0, 1'b0, 12'd2, 4'd2, 1'b1, 1'b1, w1);
      tbl[5]  = v(1'b0, 1'b0, 1'b1, 64'd0,             1'b0, 1'b0, 12'd2, 4'd2, 1'b0, 1'b1, w1);
      tbl[6]  = v(1'b0, 1'b1, 1'b0, 64'd0,             1'b0, 1'b0, 12'd1, 4'd2, 1'b0, 1'b1, bad);
      tbl[7]  = v(1'b1, 1'b0, 1'b0, mkw(63'h33),       1'b1, 1'b0, 12'd2, 4'd3, 1'b0, 1'b1, bad);
      tbl[8]  = v(1'b0, 1'b0, 1'b0, 64'd0,             1'b0, 1'b0, 12'd2, 4'd3, 1'b0, 1'b1, bad);
      tbl[9]  = v(1'b1, 1'b0, 1'b0, mkw(63'h44),       1'b1, 1'b0, 12'd3, 4'd4, 1'b0, 1'b1, bad);
      tbl[10] = v(1'b0, 1'b0, 1'b0, 64'd0,             1'b0, 1'b0, 12'd3, 4'd4, 1'b0, 1'b1, bad);
      tbl[11] = v(1'b1, 1'b0, 1'b0, mkw(63'h55),       1'b1, 1'b0, 12'd4, 4'd5, 1'b0, 1'b1, bad);
      tbl[12] = v(1'b0, 1'b0, 1'b0, 64'd0,             1'b0, 1'b0, 12'd4, 4'd5, 1'b0, 1'b1, bad);
      tbl[13] = v(1'b1, 1'b0, 1'b0, mkw(63'h66),       1'b1, 1'b0, 12'd5, 4'd6, 1'b0, 1'b1, bad);
      tbl[14] = v(1'b0, 1'b0, 1'b0, 64'd0,             1'b0, 1'b0, 12'd5, 4'd6, 1'b0, 1'b1, bad);
      tbl[15] = v(1'b1, 1'b1, 1'b0, mkw(63'h77),       1'b1, 1'b0, 12'd5, 4'd7, 1'b0, 1'b1, mkw(63'h33));
      tbl[16] = v(1'b0, 1'b0, 1'b0, 64'd0,             1'b0, 1'b0, 12'd5, 4'd7, 1'b0, 1'b1, mkw(63'h33));
      tbl[17] = v(1'b0, 1'b1, 1'b0, 64'd0,             1'b0, 1'b0, 12'd4, 4'd7, 1'b0, 1'b1, mkw(63'h44));
      tbl[18] = v(1'b0, 1'b1, 1'b0, 64'd0,             1'b0, 1'b0, 12'd3, 4'd7, 1'b0, 1'b1, mkw(63'h55));
      tbl[19] = v(1'b0, 1'b1, 1'b0, 64'd0,             1'b0, 1'b0, 12'd2, 4'd7, 1'b0, 1'b1, mkw(63'h66));
      tbl[20] = v(1'b0, 1'b1, 1'b0, 64'd0,             1'b0, 1'b0, 12'd1, 4'd7, 1'b0, 1'b1, mkw(63'h77));
      tbl[21] = v(1'b0, 1'b1, 1'b0, 64'd0,             1'b0, 1'b1, 12'd0, 4'd7, 1'b0, 1'b0, 64'd0);
      tbl[22] = v(1'b0, 1'b1, 1'b0, 64'd0,             1'b0, 1'b1, 12'd0, 4'd7, 1'b0, 1'b0, 64'd0);
      tbl[23] = v(1'b1, 1'b1, 1'b0, mkw(63'h88),       1'b1, 1'b0, 12'd1, 4'd8, 1'b0, 1'b1, mkw(63'h88));
      tbl[24] = v(1'b0, 1'b1, 1'b0, 64'd0,             1'b0, 1'b1, 12'd0, 4'd8, 1'b0, 1'b0, 64'd0);
      tbl[25] = v(1'b1, 1'b0, 1'b1, bad,               1'b1, 1'b0, 12'd1, 4'd9, 1'b1, 1'b1, bad);
      tbl[26] = v(1'b0, 1'b0, 1'b1, 64'd0,             1'b0, 1'b0, 12'd1, 4'd9, 1'b0, 1'b1, bad);

      reset_n = 1'b0;
      load_event = 1'b0; read_fifo = 1'b0; clear_flags = 1'b0; channel_event_in = 64'd0;
      #11;
      check_reset_state("reset");
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i].ld, tbl[i].rd, tbl[i].clr, tbl[i].din);
         chk($sformatf("v%0d ack", i),  64'(fifo_ack), 64'(tbl[i].ack));
         chk($sformatf("v%0d empty", i), 64'(fifo_empty), 64'(tbl[i].emp));
         chk($sformatf("v%0d full", i), 64'(fifo_full), 64'(tbl[i].full));
         chk($sformatf("v%0d half", i), 64'(fifo_half), 64'(tbl[i].half));
         chk($sformatf("v%0d cnt", i),  64'(fifo_counter), 64'(tbl[i].cnt));
         chk($sformatf("v%0d lsbs", i), 64'(total_packets_lsbs), 64'(tbl[i].lsb));
         chk($sformatf("v%0d ovf", i),  64'(fifo_overflow), 64'(tbl[i].ovf));
         chk($sformatf("v%0d perr", i), 64'(parity_error), 64'(tbl[i].perr));
         if (tbl[i].cd) chk($sformatf("v%0d dout", i), fifo_data_out, tbl[i].dout);
      end

      // Fill to full, overflow, clear, write+pop at full, then drain
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      check_reset_state("reset2");
      for (int i = 0; i < 16; i++) begin
         w = mkw(63'(i + 100));
         write_word(w, $sformatf("fill%0d", i));
         q.push_back(w);
         if (i == 7) chk("half at 8", 64'(fifo_half), 64'd1);
         if (i == 14) chk("not full at 15", 64'(fifo_full), 64'd0);
      end
      chk("full16", 64'(fifo_full), 64'd1);
      chk("half16", 64'(fifo_half), 64'd1);
      chk("cnt16",  64'(fifo_counter), 64'd16);
      chk("lsbs16", 64'(total_packets_lsbs), 64'd0);
      chk("head16", fifo_data_out, q[0]);
      drive(1'b1, 1'b0, 1'b0, mkw(63'h999));
      chk("drop ack", 64'(fifo_ack), 64'd1);
      chk("drop ovf", 64'(fifo_overflow), 64'd1);
      chk("drop cnt", 64'(fifo_counter), 64'd16);
      chk("drop lsbs", 64'(total_packets_lsbs), 64'd0);
      drive(1'b0, 1'b0, 1'b1, 64'd0);
      chk("clear ovf", 64'(fifo_overflow), 64'd0);
      w = mkw(63'hABC);
      drive(1'b1, 1'b1, 1'b0, w);
      void'(q.pop_front());
      q.push_back(w);
      chk("wr+pop full ack", 64'(fifo_ack), 64'd1);
      chk("wr+pop full cnt", 64'(fifo_counter), 64'd16);
      chk("wr+pop full ovf", 64'(fifo_overflow), 64'd0);
      chk("wrap lsbs", 64'(total_packets_lsbs), 64'd1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d dout", i), fifo_data_out, q[0]);
         drive(1'b0, 1'b1, 1'b0, 64'd0);
         void'(q.pop_front());
      end
      chk("drained empty", 64'(fifo_empty), 64'd1);
      chk("drained cnt", 64'(fifo_counter), 64'd0);
      drive(1'b0, 1'b1, 1'b0, 64'd0);
      chk("underflow cnt", 64'(fifo_counter), 64'd0);
      chk("underflow empty", 64'(fifo_empty), 64'd1);

      // Reset asserted during an ack cycle with 8 stored
      drive(1'b0, 1'b0, 1'b0, 64'd0);
      for (int i = 0; i < 8; i++) write_word(mkw(63'(i + 200)), $sformatf("pre%0d", i));
      chk("pre cnt8", 64'(fifo_counter), 64'd8);
      chk("pre half", 64'(fifo_half), 64'd1);
      drive(1'b1, 1'b0, 1'b0, mkw(63'h5A5));
      chk("pre-reset ack", 64'(fifo_ack), 64'd1);
      reset_n = 1'b0;
      #1;
      check_reset_state("midreset");
      load_event = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      w = mkw(63'h1234);
      drive(1'b1, 1'b0, 1'b0, w);
      chk("post ack", 64'(fifo_ack), 64'd1);
      chk("post empty", 64'(fifo_empty), 64'd0);
      chk("post cnt", 64'(fifo_counter), 64'd1);
      chk("post dout", fifo_data_out, w);
      drive(1'b0, 1'b0, 1'b0, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
